// File: rtl/rate_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rate_divider_pkg
// Description : Shared rate-select encodings and period helper for the
//               rate divider.
// Revision    : 1.0 - initial release
// ============================================================================
package rate_divider_pkg;

    localparam logic [1:0] SEL_FULL    = 2'b00;
    localparam logic [1:0] SEL_1HZ     = 2'b01;
    localparam logic [1:0] SEL_HALF    = 2'b10;
    localparam logic [1:0] SEL_QUARTER = 2'b11;

    // Tick period in clk cycles for a given rate select.
    function automatic int unsigned period(input logic [1:0] sel,
                                           input int unsigned clk_hz);
        case (sel)
            SEL_FULL:  return 1;
            SEL_1HZ:   return clk_hz;
            SEL_HALF:  return 2 * clk_hz;
            default:   return 4 * clk_hz;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rate_divider_step_sync.sv
`default_nettype none
// ============================================================================
// Module      : step_sync
// Description : Two-flop synchronizer plus rising-edge detector for the
//               asynchronous manual-step key.
// Revision    : 1.0 - initial release
// ============================================================================
module step_sync (
    input  logic clk,
    input  logic clr,
    input  logic step_async,
    output logic step_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= step_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign step_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : rate_divider
// Description : Programmable down-counting rate divider producing a
//               single-cycle enable tick. Define RATE_DIVIDER_STEP_EN to add
//               the manual step key input.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_divider
    import rate_divider_pkg::*;
#(
    parameter  int unsigned CLK_HZ = 50000000,
    localparam int unsigned CNT_W  = $clog2(4 * CLK_HZ)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [1:0]       sel,
`ifdef RATE_DIVIDER_STEP_EN
    input  logic             step,
`endif
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [1:0]       r_sel_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [CNT_W-1:0] w_load_new;
    logic [CNT_W-1:0] w_load_cur;
    logic             w_sel_chg;
    logic             w_nat_tick;
    logic             w_step_pulse;

    assign w_load_new = CNT_W'(period(sel, CLK_HZ) - 1);
    assign w_load_cur = CNT_W'(period(r_sel_q, CLK_HZ) - 1);
    assign w_sel_chg  = (sel != r_sel_q);
    assign w_nat_tick = !w_sel_chg && run && (r_cnt == '0);

`ifdef RATE_DIVIDER_STEP_EN
    step_sync u_step_sync (
        .clk        (clk),
        .clr        (clr),
        .step_async (step),
        .step_pulse (w_step_pulse)
    );
`else
    assign w_step_pulse = 1'b0;
`endif

    // A rate change always wins so the new period starts from a clean reload.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sel_q <= SEL_FULL;
            r_cnt   <= '0;
        end else if (w_sel_chg) begin
            r_sel_q <= sel;
            r_cnt   <= w_load_new;
        end else if (run) begin
            if (r_cnt == '0) begin
                r_cnt <= w_load_cur;
            end else begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    // Step and natural tick share one register, so coincident events merge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_nat_tick | w_step_pulse;
        end
    end

    assign tick = r_tick;
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_divider
// Description : Self-checking bench for rate_divider with CLK_HZ=4; directed
//               scenarios followed by randomized stimulus against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_divider;

    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned CNT_W  = $clog2(4 * CLK_HZ);

    logic             clk  = 1'b0;
    logic             clr  = 1'b0;
    logic             run  = 1'b0;
    logic [1:0]       sel  = 2'b00;
    logic             step = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: progress counter of run edges since the last reload.
    int m_sel_q;
    int m_k;
    int m_cnt;
    bit m_tick;
    bit step_hist[$];

    rate_divider #(.CLK_HZ(CLK_HZ)) dut (
        .clk  (clk),
        .clr  (clr),
        .run  (run),
        .sel  (sel),
`ifdef RATE_DIVIDER_STEP_EN
        .step (step),
`endif
        .tick (tick),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int per(input int s);
        case (s)
            0:       return 1;
            1:       return CLK_HZ;
            2:       return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    function automatic void model_reset();
        m_sel_q = 0;
        m_k     = 0;
        m_cnt   = 0;
        m_tick  = 0;
        step_hist.delete();
    endfunction

    function automatic void model_edge();
        bit nat   = 0;
        bit pulse = 0;
        int n;
        if (int'(sel) != m_sel_q) begin
            m_sel_q = int'(sel);
            m_k     = 0;
        end else if (run) begin
            m_k++;
            nat = ((m_k % per(m_sel_q)) == 0);
        end
        step_hist.push_back(step);
        if (step_hist.size() > 8) void'(step_hist.pop_front());
        n = step_hist.size();
`ifdef RATE_DIVIDER_STEP_EN
        // Key level seen two edges ago, low three edges ago -> tick this edge.
        if (n >= 3) pulse = step_hist[n-3] && !((n >= 4) ? step_hist[n-4] : 1'b0);
`endif
        m_tick = nat | pulse;
        m_cnt  = per(m_sel_q) - 1 - (m_k % per(m_sel_q));
    endfunction

    task automatic edge_chk();
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt", cnt, m_cnt);
        chk("tick", tick, m_tick);
    endtask

    task automatic mid_clr();
        #2 clr = 1'b0;
        #1;
        chk("clr_cnt", cnt, 0);
        chk("clr_tick", tick, 0);
        model_reset();
        #1 clr = 1'b1;
    endtask

    initial begin
        int n;
        int nt;
        int first;
        logic [CNT_W-1:0] held;

        model_reset();

        // Reset held across clock edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_tick", tick, 0);
        @(negedge clk) clr = 1'b1;

        // sel=01: reload to 3, then a tick every 4th edge
        sel = 2'b01; run = 1'b1;
        edge_chk();
        chk("s1_reload", cnt, 3);
        nt = 0;
        for (int i = 0; i < 8; i++) begin
            edge_chk();
            if (tick === 1'b1) nt++;
        end
        chk("s1_ticks", nt, 2);

        // sel=00: tick every edge, cnt stays 0
        sel = 2'b00;
        edge_chk();
        chk("s0_chg_tick", tick, 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            edge_chk();
            if (tick === 1'b1) nt++;
        end
        chk("s0_ticks", nt, 10);

        // sel=11: pause at 9 for 5 cycles
        sel = 2'b11;
        edge_chk();
        for (int i = 0; i < 40 && m_cnt != 9; i++) edge_chk();
        chk("q_at9", cnt, 9);
        run = 1'b0;
        for (int i = 0; i < 5; i++) edge_chk();
        chk("q_hold", cnt, 9);
        run = 1'b1;
        n = 0;
        do begin edge_chk(); n++; end while (tick !== 1'b1 && n < 40);
        chk("q_resume_edges", n, 10);

        // 01 -> 10 switch at cnt=2
        sel = 2'b01;
        edge_chk();
        for (int i = 0; i < 40 && m_cnt != 2; i++) edge_chk();
        chk("sw_at2", cnt, 2);
        sel = 2'b10;
        edge_chk();
        chk("sw_cnt", cnt, 7);
        chk("sw_tick", tick, 0);
        n = 0;
        do begin edge_chk(); n++; end while (tick !== 1'b1 && n < 40);
        chk("sw_next_tick", n, 8);

        // Asynchronous clr at cnt=1, no tick while run stays low
        for (int i = 0; i < 40 && m_cnt != 1; i++) edge_chk();
        chk("ac_at1", cnt, 1);
        run = 1'b0;
        mid_clr();
        nt = 0;
        for (int i = 0; i < 4; i++) begin
            edge_chk();
            if (tick === 1'b1) nt++;
        end
        chk("ac_no_tick", nt, 0);

`ifdef RATE_DIVIDER_STEP_EN
        // Manual step with run=0: one tick on the third edge, cnt unchanged
        held  = cnt;
        step  = 1'b1;
        nt    = 0;
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            edge_chk();
            step = 1'b0;
            if (tick === 1'b1) begin
                nt++;
                if (first == 0) first = i;
            end
        end
        chk("step_ticks", nt, 1);
        chk("step_edge", first, 3);
        chk("step_cnt", cnt, held);

        // Step landing on a natural tick merges into one
        sel = 2'b01; run = 1'b1;
        edge_chk();
        for (int i = 0; i < 40 && m_cnt != 2; i++) edge_chk();
        step = 1'b1;
        nt   = 0;
        for (int i = 0; i < 4; i++) begin
            edge_chk();
            step = 1'b0;
            if (tick === 1'b1) nt++;
        end
        chk("merge_ticks", nt, 1);
`endif

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
            run = ($urandom_range(0, 3) != 0);
`ifdef RATE_DIVIDER_STEP_EN
            if ($urandom_range(0, 7) == 0) step = ~step;
`endif
            if ($urandom_range(0, 149) == 0) mid_clr();
            edge_chk();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rate_divider.md
RATE_DIVIDER -- requirements
Module: rate_divider

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clk frequency in Hz and the cycle count of the 1 Hz period.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  enable for counting; run=0 freezes the divider.
REQ-005 SHALL have port sel  input  2  rate select: 00 every cycle, 01 period CLK_HZ, 10 period 2*CLK_HZ, 11 period 4*CLK_HZ.
REQ-006 SHALL have port tick  output  1  single-cycle enable pulse that drives the downstream counter's enable input.
REQ-007 SHALL have port cnt  output  CNT_W  current down-counter value, CNT_W = clog2(4*CLK_HZ).

Function
REQ-008 SHALL define period P(sel) as 1, CLK_HZ, 2*CLK_HZ, 4*CLK_HZ for sel 00/01/10/11.
REQ-009 SHALL hold a registered copy sel_q of sel.
REQ-010 SHALL give sel change priority: on an edge with sel != sel_q, set sel_q<=sel, cnt<=P(sel)-1 and tick<=0, regardless of run.
REQ-011 SHALL reload on terminal count: else, on an edge with run=1 and cnt==0, set cnt<=P(sel_q)-1 and tick<=1.
REQ-012 SHALL decrement otherwise: else, on an edge with run=1 and cnt!=0, set cnt<=cnt-1 and tick<=0.
REQ-013 SHALL hold cnt and drive tick<=0 on any edge with run=0.
REQ-014 SHALL make tick a registered output, never high for more than one consecutive cycle except when sel_q=00 and run=1, where it stays high every cycle.
REQ-015 SHALL produce exactly P(sel_q) cycles between consecutive ticks in steady state with run held at 1.
REQ-016 SHALL pause a run=0 interval: no ticks lost or added, and the tick spacing extends by the paused cycles.
REQ-017 SHALL never underflow or exceed P(sel_q)-1 in cnt; all arithmetic is unsigned at CNT_W bits.

Reset
REQ-018 SHALL on clr=0 asynchronously force cnt=0, tick=0 and sel_q=00.
REQ-019 SHALL keep outputs at their reset values while clr=0, independent of clk.
REQ-020 SHALL produce a tick on the first run=1 edge after clr rises when sel=00.
REQ-021 SHALL, for any other sel after reset, take the sel-change reload first, so the first tick occurs P(sel) edges after the reload edge.
REQ-022 SHALL, when clr asserts mid-count, abandon the count and emit no pending tick.

Configuration
REQ-023 SHALL, with macro RATE_DIVIDER_STEP_EN defined, add port step  input  1, an asynchronous manual-step key.
REQ-024 SHALL, with RATE_DIVIDER_STEP_EN defined, pass step through a 2-flop synchronizer and rising-edge detector.
REQ-025 SHALL, with RATE_DIVIDER_STEP_EN defined, make each detected rising edge force tick=1 for one cycle regardless of run, leaving cnt unaffected.
REQ-026 SHALL merge a step edge that coincides with a natural tick into a single one-cycle tick.
REQ-027 SHALL reset the synchronizer flops to 0 on clr.
REQ-028 SHALL, without RATE_DIVIDER_STEP_EN, have no step port and no synchronizer logic.

Structure
REQ-029 SHALL put the sel encoding constants (SEL_FULL, SEL_1HZ, SEL_HALF, SEL_QUARTER) and the period function in shared package rate_divider_pkg.
REQ-030 SHALL implement the synchronizer and edge detector as sub-module step_sync, instantiated only under RATE_DIVIDER_STEP_EN.

Verification (CLK_HZ=4)
REQ-031 SHALL cover: reset, sel=01, run=1 -> reload edge sets cnt=3, then tick on every 4th edge (cnt 3,2,1,0).
REQ-032 SHALL cover: sel=00, run=1 for 10 edges -> tick high on all 10 edges, cnt stays 0.
REQ-033 SHALL cover: sel=11, run=1, then run=0 for 5 cycles at cnt=9 -> cnt holds 9, and the next tick arrives 5 cycles late.
REQ-034 SHALL cover: sel 01->10 switched at cnt=2 -> cnt=7 on the change edge, no tick, next tick 8 edges later.
REQ-035 SHALL cover: clr pulsed low between edges at cnt=1 -> cnt=0 and tick=0 immediately, with no tick afterward until run resumes.
REQ-036 SHALL cover, with RATE_DIVIDER_STEP_EN: run=0, step pulsed -> exactly one tick 3 edges later with cnt unchanged; a step coinciding with a natural tick -> one tick only.
